// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the execute-stage multiply/divide unit.
// MULDIV_MADD_EN enables the multiply-accumulate family (MADD/MADDU/MSUB/MSUBU).
package muldiv_pkg;

    // Operation codes presented by the E stage alongside md_start.
    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MFHI    = 4'd5,
        MFLO    = 4'd6,
        MTHI    = 4'd7,
        MTLO    = 4'd8,
        MADD    = 4'd9,
        MADDU   = 4'd10,
        MSUB    = 4'd11,
        MSUBU   = 4'd12
    } md_op_t;

    // Busy-tracking FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Multi-cycle operations that use the multiplier latency.
    function automatic logic md_is_mul(input md_op_t op);
        logic r;
        r = (op == MULT) || (op == MULTU);
`ifdef MULDIV_MADD_EN
        r = r || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
`endif
        return r;
    endfunction

    // Multi-cycle operations that use the divider latency.
    function automatic logic md_is_div(input md_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generator: operands, opcode and current HI/LO in,
// 64-bit {HI,LO} result out. Handles signed/unsigned multiply, truncating
// divide, divide-by-zero, and (with MULDIV_MADD_EN) accumulate forms.
module md_calc
    import muldiv_pkg::*;
(
    input  md_op_t      op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] result_o
);

    logic        mul_signed;
    logic [63:0] rs_ext;
    logic [63:0] rt_ext;
    logic [63:0] product;

    logic        div_signed;
    logic        rs_neg;
    logic        rt_neg;
    logic        rt_zero;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Operand extension and full-width product shared by MULT* and MADD*/MSUB*.
    always_comb begin
        mul_signed = (op_i == MULT) || (op_i == MADD) || (op_i == MSUB);
        rs_ext     = mul_signed ? {{32{rs_i[31]}}, rs_i} : {32'd0, rs_i};
        rt_ext     = mul_signed ? {{32{rt_i[31]}}, rt_i} : {32'd0, rt_i};
        product    = rs_ext * rt_ext;
    end

    // One unsigned divider on magnitudes; signs restored afterwards so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    always_comb begin
        div_signed = (op_i == DIV);
        rs_neg     = div_signed & rs_i[31];
        rt_neg     = div_signed & rt_i[31];
        rt_zero    = (rt_i == 32'd0);
        rs_mag     = rs_neg ? (32'd0 - rs_i) : rs_i;
        rt_mag     = rt_zero ? 32'd1 : (rt_neg ? (32'd0 - rt_i) : rt_i);
        quot_mag   = rs_mag / rt_mag;
        rem_mag    = rs_mag % rt_mag;
        quot       = (rs_neg ^ rt_neg) ? (32'd0 - quot_mag) : quot_mag;
        rem        = rs_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    // Select the 64-bit result that will be latched into the shadow registers.
    always_comb begin
        result_o = {hi_i, lo_i};
        case (op_i)
            MULT, MULTU: result_o = product;
            DIV, DIVU:   result_o = rt_zero ? {rs_i, 32'hFFFF_FFFF} : {rem, quot};
`ifdef MULDIV_MADD_EN
            MADD, MADDU: result_o = {hi_i, lo_i} + product;
            MSUB, MSUBU: result_o = {hi_i, lo_i} - product;
`endif
            default:     result_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// Execute-stage multiply/divide unit with architectural HI/LO.
// A multi-cycle op computes its result into shadow registers at the start
// edge, holds md_busy for MULT_CYCLES/DIV_CYCLES cycles, then commits.
// MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU (otherwise those codes are ignored).
// MULDIV_HAZARD_CHECK enables an assertion on md_start arriving while busy.
module e_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] v_R1_E,
    input  logic [31:0] v_R2_E,
    output logic        md_busy,
    output logic [31:0] md_rdata,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_op_t          op;
    md_state_t       state_q;
    md_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic [31:0]     shi_q;
    logic [31:0]     slo_q;
    logic [63:0]     calc_result;

    logic            idle;
    logic            start_long;
    logic            start_div;
    logic            start_mthi;
    logic            start_mtlo;
    logic            last_cycle;

    assign op = md_op_t'(md_op);

    // Decode which kind of start (if any) is accepted this cycle.
    always_comb begin
        idle       = (state_q == ST_IDLE);
        start_div  = md_start && idle && md_is_div(op);
        start_long = md_start && idle && (md_is_mul(op) || md_is_div(op));
        start_mthi = md_start && idle && (op == MTHI);
        start_mtlo = md_start && idle && (op == MTLO);
        last_cycle = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));
    end

    md_calc u_md_calc (
        .op_i     (op),
        .rs_i     (v_R1_E),
        .rt_i     (v_R2_E),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .result_o (calc_result)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE -> RUN on an accepted long op, RUN -> IDLE on the last count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_long) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and the combinational HI/LO read port.
    always_comb begin
        md_busy  = (state_q == ST_RUN);
        md_rdata = 32'd0;
        if (op == MFHI) md_rdata = hi_q;
        if (op == MFLO) md_rdata = lo_q;
    end

    // Countdown, shadow capture, commit and direct MTHI/MTLO writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            shi_q <= 32'd0;
            slo_q <= 32'd0;
        end else begin
            if (start_long) begin
                {shi_q, slo_q} <= calc_result;
                cnt_q          <= start_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (last_cycle) begin
                hi_q <= shi_q;
                lo_q <= slo_q;
            end
            if (start_mthi) hi_q <= v_R1_E;
            if (start_mtlo) lo_q <= v_R1_E;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

`ifdef MULDIV_HAZARD_CHECK
    // The hazard unit must never let a state-changing md op reach E while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(md_start && md_busy &&
                      (md_is_mul(op) || md_is_div(op) || op == MTHI || op == MTLO)));
        end
    end
`endif

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed bench for e_muldiv_unit: a behavioural HI/LO model checked every
// cycle, plus hand-computed literal expectations after each transaction.
module tb_e_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        md_start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] v_R1_E = 32'd0;
    logic [31:0] v_R2_E = 32'd0;
    logic        md_busy;
    logic [31:0] md_rdata;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    e_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_op    (md_op),
        .v_R1_E   (v_R1_E),
        .v_R2_E   (v_R2_E),
        .md_busy  (md_busy),
        .md_rdata (md_rdata),
        .HI       (HI),
        .LO       (LO)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    int          m_left = 0;

    function automatic bit ref_is_long(input logic [3:0] op);
        bit r;
        r = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
`ifdef MULDIV_MADD_EN
        r = r || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
`endif
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] op);
        return ((op == DIV) || (op == DIVU)) ? 10 : 5;
    endfunction

    // Architectural result from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint a, b;
        logic [63:0] sp, up;
        a  = longint'($signed(rs));
        b  = longint'($signed(rt));
        sp = a * b;
        up = {32'd0, rs} * {32'd0, rt};
        case (op)
            MULT:  return sp;
            MULTU: return up;
            DIV:   if (rt == 0) return {rs, 32'hFFFF_FFFF};
                   else return {32'(a % b), 32'(a / b)};
            DIVU:  if (rt == 0) return {rs, 32'hFFFF_FFFF};
                   else return {rs % rt, rs / rt};
            MADD:  return {hi, lo} + sp;
            MADDU: return {hi, lo} + up;
            MSUB:  return {hi, lo} - sp;
            MSUBU: return {hi, lo} - up;
            default: return {hi, lo};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi <= 0; m_lo <= 0; m_phi <= 0; m_plo <= 0; m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else if (md_start) begin
            if (ref_is_long(md_op)) begin
                {m_phi, m_plo} <= ref_result(md_op, v_R1_E, v_R2_E, m_hi, m_lo);
                m_left         <= ref_latency(md_op);
            end else if (md_op == MTHI) begin
                m_hi <= v_R1_E;
            end else if (md_op == MTLO) begin
                m_lo <= v_R1_E;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_busy", {31'd0, md_busy}, {31'd0, (m_left > 0)});
                check("model_hi", HI, m_hi);
                check("model_lo", LO, m_lo);
                if (md_op == MFHI) check("model_mfhi", md_rdata, m_hi);
                if (md_op == MFLO) check("model_mflo", md_rdata, m_lo);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk); #2;
        md_start = 1'b1; md_op = op; v_R1_E = rs; v_R2_E = rt;
        $display("txn op=%0d rs=%h rt=%h", op, rs, rt);
        @(posedge clk); #2;
        md_start = 1'b0; md_op = MD_NONE;
    endtask

    // Count remaining busy cycles; a unit stuck busy is a failed comparison.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_busy) n++;
            else break;
        end
        if (md_busy) begin
            n_cmp++; n_bad++;
            $display("FAIL busy_timeout: got busy=1 expected busy=0 within 40 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, rs, rt);
        wait_idle(n);
        check({name, "_busy"}, n, exp_busy);
        check({name, "_hi"}, HI, exp_hi);
        check({name, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fork compare_loop(); join_none

        // Reset state
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", {31'd0, md_busy}, 32'd0);

        run_op("mult_neg", MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu",     DIVU,  32'd7,         32'd2, 10, 32'd1, 32'd3);
        run_op("div_neg",  DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_zero", DIV,   32'd5,         32'd0, 10, 32'd5, 32'hFFFF_FFFF);
        run_op("div_ovf",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1);

        // MTHI/MTLO then MFHI/MFLO read back in the same cycle; no busy
        run_op("mthi", MTHI, 32'h0000_1234, 32'd0, 0, 32'h0000_1234, 32'd1);
        run_op("mtlo", MTLO, 32'h0000_ABCD, 32'd0, 0, 32'h0000_1234, 32'h0000_ABCD);
        @(posedge clk); #2 md_op = MFHI; md_start = 1'b1;
        $display("txn op=%0d (read HI)", MFHI);
        #3 check("mfhi_rdata", md_rdata, 32'h0000_1234);
        check("mfhi_busy", {31'd0, md_busy}, 32'd0);
        @(posedge clk); #2 md_op = MFLO;
        $display("txn op=%0d (read LO)", MFLO);
        #3 check("mflo_rdata", md_rdata, 32'h0000_ABCD);
        @(posedge clk); #2 md_op = MD_NONE; md_start = 1'b0;

        // Non-md codes are ignored
        run_op("op_none", MD_NONE, 32'hDEAD_BEEF, 32'd1, 0, 32'h0000_1234, 32'h0000_ABCD);
        run_op("op_15",   4'hF,    32'hDEAD_BEEF, 32'd1, 0, 32'h0000_1234, 32'h0000_ABCD);

        // md_start during busy is ignored; original MULT still commits on time
        issue(MULT, 32'd2, 32'd3);
        issue(DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check("overlap_busy", n, 32'd3);
        check("overlap_hi", HI, 32'd0);
        check("overlap_lo", LO, 32'd6);

        // Reset three cycles into a MULT: nothing commits afterwards
        issue(MULT, 32'd7, 32'd9);
        @(posedge clk); @(posedge clk); #2 reset = 1'b1;
        $display("txn reset mid-operation");
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, md_busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);

        // Accumulate: HI=0, LO=0xFFFFFFFF, MADDU 1*1
        run_op("pre_mtlo", MTLO, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
`ifdef MULDIV_MADD_EN
        run_op("maddu", MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
        run_op("msub",  MSUB,  32'd1, 32'hFFFF_FFFF, 5, 32'd1, 32'd1);
`else
        run_op("maddu_off", MADDU, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
